regfile_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the 32x32 register file (two read ports BusA/BusB, one write port BusW with RegWr). It accepts read/write commands from two independent masters, selects one per transaction with round-robin priority, drives the register-file address/data/write-enable for exactly one cycle, and returns the read data through a valid/ready response channel. It sits between the masters and the register file, and is the only driver of RA, RB, RW, BusW and RegWr.

---
 rtl/regfile_arbiter.sv | 150 +++++++++++++++
 tb/tb_regfile_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_arbiter.sv
// regfile_arbiter: round-robin arbiter and sequencer between two command
// masters and a 32x32 register file. A command is accepted in IDLE, drives the
// register file for exactly one cycle in ISSUE, and its read data is held in
// RESP until the owning requester takes it.
module regfile_arbiter (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [1:0]  ReqValid,
  output logic [1:0]  ReqReady,
  input  logic [1:0]  ReqWr,
  input  logic [9:0]  ReqRA,
  input  logic [9:0]  ReqRB,
  input  logic [9:0]  ReqRW,
  input  logic [63:0] ReqData,
  output logic [1:0]  RspValid,
  input  logic [1:0]  RspReady,
  output logic [31:0] RspA,
  output logic [31:0] RspB,
  output logic        Busy,
  output logic [4:0]  RA,
  output logic [4:0]  RB,
  output logic [4:0]  RW,
  output logic [31:0] BusW,
  output logic        RegWr,
  input  logic [31:0] BusA,
  input  logic [31:0] BusB
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        prio_q, prio_d;
  logic        grant_q, grant_d;
  logic        wr_q, wr_d;
  logic [4:0]  ra_q, ra_d;
  logic [4:0]  rb_q, rb_d;
  logic [4:0]  rw_q, rw_d;
  logic [31:0] data_q, data_d;
  logic [31:0] rsp_a_q, rsp_a_d;
  logic [31:0] rsp_b_q, rsp_b_d;

  logic        grant_sel;
  logic [1:0]  req_ready;

  // Next-state logic: pick a winner in IDLE, capture read data at the end of
  // ISSUE, and hand the priority to the other requester when a response drains.
  always_comb begin
    state_d   = state_q;
    prio_d    = prio_q;
    grant_d   = grant_q;
    wr_d      = wr_q;
    ra_d      = ra_q;
    rb_d      = rb_q;
    rw_d      = rw_q;
    data_d    = data_q;
    rsp_a_d   = rsp_a_q;
    rsp_b_d   = rsp_b_q;
    req_ready = 2'b00;

    if (ReqValid == 2'b11) begin
      grant_sel = prio_q;
    end else begin
      grant_sel = ReqValid[1];
    end

    case (state_q)
      IDLE: begin
        if (|ReqValid) begin
          req_ready = grant_sel ? 2'b10 : 2'b01;
          grant_d   = grant_sel;
          wr_d      = grant_sel ? ReqWr[1]         : ReqWr[0];
          ra_d      = grant_sel ? ReqRA[9:5]       : ReqRA[4:0];
          rb_d      = grant_sel ? ReqRB[9:5]       : ReqRB[4:0];
          rw_d      = grant_sel ? ReqRW[9:5]       : ReqRW[4:0];
          data_d    = grant_sel ? ReqData[63:32]   : ReqData[31:0];
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        rsp_a_d = BusA;
        rsp_b_d = BusB;
        state_d = RESP;
      end
      RESP: begin
        if (RspReady[grant_q]) begin
          prio_d  = ~grant_q;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control state: FSM, priority pointer and the id of the current owner.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      grant_q <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      grant_q <= grant_d;
    end
  end

  // Datapath state: latched command (which also holds the register-file
  // address/data outputs between commands) and the captured read data.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wr_q    <= 1'b0;
      ra_q    <= 5'd0;
      rb_q    <= 5'd0;
      rw_q    <= 5'd0;
      data_q  <= 32'd0;
      rsp_a_q <= 32'd0;
      rsp_b_q <= 32'd0;
    end else begin
      wr_q    <= wr_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      rw_q    <= rw_d;
      data_q  <= data_d;
      rsp_a_q <= rsp_a_d;
      rsp_b_q <= rsp_b_d;
    end
  end

  // Outputs: ReqReady is masked by Reset so nothing is offered while reset is
  // held; writes to R0 are dropped but the command still completes.
  always_comb begin
    ReqReady = Reset ? 2'b00 : req_ready;
    RspValid = (state_q == RESP) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
    RegWr    = (state_q == ISSUE) && wr_q && (rw_q != 5'd0);
    Busy     = (state_q != IDLE);
    RA       = ra_q;
    RB       = rb_q;
    RW       = rw_q;
    BusW     = data_q;
    RspA     = rsp_a_q;
    RspB     = rsp_b_q;
  end

endmodule

// File: tb/tb_regfile_arbiter.sv
// tb_regfile_arbiter: drives directed and random commands from two masters,
// models the register file as the environment, and checks every cycle of each
// transaction against a transaction-level reference (memory array + priority).
module tb_regfile_arbiter;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [1:0]  ReqValid;
  logic [1:0]  ReqReady;
  logic [1:0]  ReqWr;
  logic [9:0]  ReqRA, ReqRB, ReqRW;
  logic [63:0] ReqData;
  logic [1:0]  RspValid;
  logic [1:0]  RspReady;
  logic [31:0] RspA, RspB;
  logic        Busy;
  logic [4:0]  RA, RB, RW;
  logic [31:0] BusW;
  logic        RegWr;
  logic [31:0] BusA, BusB;

  logic [31:0] rf [32];
  logic [31:0] modelMem [32];
  bit          modelPrio;
  int          errors = 0;
  int          checks = 0;

  regfile_arbiter dut (
    .Clk(Clk), .Reset(Reset),
    .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWr(ReqWr),
    .ReqRA(ReqRA), .ReqRB(ReqRB), .ReqRW(ReqRW), .ReqData(ReqData),
    .RspValid(RspValid), .RspReady(RspReady), .RspA(RspA), .RspB(RspB),
    .Busy(Busy), .RA(RA), .RB(RB), .RW(RW), .BusW(BusW), .RegWr(RegWr),
    .BusA(BusA), .BusB(BusB)
  );

  // Free-running clock, posedge at 5, 15, 25 ...
  always #5 Clk = ~Clk;

  // Register file seen by the arbiter: combinational reads, write on posedge.
  always_comb begin
    BusA = rf[RA];
    BusB = rf[RB];
  end

  always @(posedge Clk) begin
    if (RegWr) rf[RW] <= BusW;
  end

  // Single comparison point: counts the check and reports a mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Loads the command fields of requester r without touching ReqValid.
  task automatic setCmd(input int r, input bit wr, input logic [4:0] ra, input logic [4:0] rb,
                        input logic [4:0] rw, input logic [31:0] data);
    ReqWr[r]          = wr;
    ReqRA[r*5 +: 5]   = ra;
    ReqRB[r*5 +: 5]   = rb;
    ReqRW[r*5 +: 5]   = rw;
    ReqData[r*32 +: 32] = data;
  endtask

  // Runs one full transaction starting at a negedge with the arbiter idle.
  // The response is held off for 'stall' cycles before RspReady is given.
  task automatic applyStimulus(input logic [1:0] valid, input int stall, input bit dropValid);
    int          g;
    bit          ewr;
    logic [4:0]  era, erb, erw;
    logic [31:0] edata, expA, expB;
    logic [1:0]  onehot;

    ReqValid = valid;
    RspReady = 2'b00;
    #1;
    if (valid == 2'b11) g = int'(modelPrio);
    else                g = valid[1] ? 1 : 0;
    onehot = (g == 1) ? 2'b10 : 2'b01;
    ewr   = ReqWr[g];
    era   = ReqRA[g*5 +: 5];
    erb   = ReqRB[g*5 +: 5];
    erw   = ReqRW[g*5 +: 5];
    edata = ReqData[g*32 +: 32];
    expA  = modelMem[era];
    expB  = modelMem[erb];
    checkOutput("accept_ReqReady", {30'd0, ReqReady}, {30'd0, onehot});
    checkOutput("accept_Busy", {31'd0, Busy}, 32'd0);
    checkOutput("accept_RspValid", {30'd0, RspValid}, 32'd0);

    @(negedge Clk);
    if (dropValid) ReqValid = 2'b00;
    #1;
    checkOutput("issue_RegWr", {31'd0, RegWr}, {31'd0, (ewr && erw != 5'd0)});
    checkOutput("issue_RA", {27'd0, RA}, {27'd0, era});
    checkOutput("issue_RB", {27'd0, RB}, {27'd0, erb});
    checkOutput("issue_RW", {27'd0, RW}, {27'd0, erw});
    checkOutput("issue_BusW", BusW, edata);
    checkOutput("issue_ReqReady", {30'd0, ReqReady}, 32'd0);
    checkOutput("issue_RspValid", {30'd0, RspValid}, 32'd0);
    checkOutput("issue_Busy", {31'd0, Busy}, 32'd1);

    @(negedge Clk);
    for (int i = 0; i < stall; i++) begin
      RspReady = ~onehot;
      #1;
      checkOutput("stall_RspValid", {30'd0, RspValid}, {30'd0, onehot});
      checkOutput("stall_RspA", RspA, expA);
      checkOutput("stall_RspB", RspB, expB);
      checkOutput("stall_ReqReady", {30'd0, ReqReady}, 32'd0);
      checkOutput("stall_Busy", {31'd0, Busy}, 32'd1);
      checkOutput("stall_RegWr", {31'd0, RegWr}, 32'd0);
      @(negedge Clk);
    end
    RspReady = onehot | 2'($urandom_range(0, 3));
    #1;
    checkOutput("resp_RspValid", {30'd0, RspValid}, {30'd0, onehot});
    checkOutput("resp_RspA", RspA, expA);
    checkOutput("resp_RspB", RspB, expB);
    checkOutput("resp_RegWr", {31'd0, RegWr}, 32'd0);
    @(negedge Clk);
    RspReady = 2'b00;

    modelPrio = (g == 0);
    if (ewr && erw != 5'd0) modelMem[erw] = edata;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      rf[i]       = (i == 0) ? 32'd0 : $urandom;
      modelMem[i] = rf[i];
    end
    modelPrio = 1'b0;
    ReqValid  = 2'b11;
    ReqWr     = 2'b00;
    ReqRA     = '0;
    ReqRB     = '0;
    ReqRW     = '0;
    ReqData   = '0;
    RspReady  = 2'b00;
    Reset     = 1'b1;

    // Reset values, with requests pending to confirm nothing is offered.
    #2;
    checkOutput("rst_ReqReady", {30'd0, ReqReady}, 32'd0);
    checkOutput("rst_RspValid", {30'd0, RspValid}, 32'd0);
    checkOutput("rst_Busy", {31'd0, Busy}, 32'd0);
    checkOutput("rst_RegWr", {31'd0, RegWr}, 32'd0);
    checkOutput("rst_RspA", RspA, 32'd0);
    checkOutput("rst_RspB", RspB, 32'd0);
    checkOutput("rst_RA", {27'd0, RA}, 32'd0);
    checkOutput("rst_RW", {27'd0, RW}, 32'd0);
    checkOutput("rst_BusW", BusW, 32'd0);
    @(negedge Clk);
    ReqValid = 2'b00;
    Reset    = 1'b0;
    @(negedge Clk);

    // Write 0xDEADBEEF to R7, then read R7/R0.
    setCmd(0, 1'b1, 5'd1, 5'd2, 5'd7, 32'hDEADBEEF);
    applyStimulus(2'b01, 0, 1'b1);
    setCmd(0, 1'b0, 5'd7, 5'd0, 5'd9, 32'h0);
    applyStimulus(2'b01, 0, 1'b1);
    checkOutput("dir_R7_readback", RspA, 32'hDEADBEEF);

    // Write to R0 from requester 1 is suppressed; then read R0.
    setCmd(1, 1'b1, 5'd0, 5'd0, 5'd0, 32'h12345678);
    applyStimulus(2'b10, 0, 1'b1);
    setCmd(1, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0);
    applyStimulus(2'b10, 0, 1'b1);
    checkOutput("dir_R0_read", RspA, 32'd0);

    // Same-index read/write returns the pre-write value.
    setCmd(0, 1'b1, 5'd4, 5'd4, 5'd3, 32'h9);
    applyStimulus(2'b01, 0, 1'b1);
    setCmd(0, 1'b1, 5'd3, 5'd0, 5'd3, 32'h5);
    applyStimulus(2'b01, 0, 1'b1);
    checkOutput("dir_same_idx_old", RspA, 32'h9);
    setCmd(0, 1'b0, 5'd3, 5'd3, 5'd0, 32'h0);
    applyStimulus(2'b01, 0, 1'b1);
    checkOutput("dir_same_idx_new", RspA, 32'h5);

    // Round robin with both requesters valid continuously.
    setCmd(0, 1'b0, 5'd7, 5'd3, 5'd0, 32'h0);
    setCmd(1, 1'b0, 5'd3, 5'd7, 5'd0, 32'h0);
    for (int i = 0; i < 4; i++) applyStimulus(2'b11, 0, 1'b0);

    // Reset in the middle of a write to R5: everything drops before the edge.
    setCmd(0, 1'b1, 5'd5, 5'd5, 5'd5, 32'hA5A5A5A5);
    ReqValid = 2'b01;
    #1;
    checkOutput("midrst_accept", {30'd0, ReqReady}, {30'd0, 2'b01});
    @(negedge Clk);
    #1;
    checkOutput("midrst_RegWr_before", {31'd0, RegWr}, 32'd1);
    Reset = 1'b1;
    #1;
    checkOutput("midrst_RegWr", {31'd0, RegWr}, 32'd0);
    checkOutput("midrst_RspValid", {30'd0, RspValid}, 32'd0);
    checkOutput("midrst_Busy", {31'd0, Busy}, 32'd0);
    checkOutput("midrst_ReqReady", {30'd0, ReqReady}, 32'd0);
    @(negedge Clk);
    ReqValid  = 2'b00;
    Reset     = 1'b0;
    modelPrio = 1'b0;
    @(negedge Clk);

    // Backpressure on requester 0 (which also re-reads R5), then requester 1.
    setCmd(0, 1'b0, 5'd5, 5'd7, 5'd0, 32'h0);
    setCmd(1, 1'b0, 5'd3, 5'd5, 5'd0, 32'h0);
    applyStimulus(2'b11, 10, 1'b0);
    applyStimulus(2'b11, 0, 1'b1);

    // Random traffic against the reference model.
    for (int n = 0; n < 40; n++) begin
      logic [1:0] v;
      for (int r = 0; r < 2; r++) begin
        setCmd(r, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)), $urandom);
      end
      v = 2'($urandom_range(1, 3));
      applyStimulus(v, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Guard against a stuck simulation.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: got no end expected end");
    $fatal(1, "[TB] timeout");
  end

endmodule
